avr_bus_master: RTL and testbench

- Initiator-side counterpart of the CPLD address shift register and SRAM bus FSM.
- Accepts parallel read/write commands (21-bit address, 8-bit data).
- Shifts the address serially onto `avr_si`, MSB first, then latches it with `avr_sreg_en`.
- Performs the SRAM access handshake on `avr_oe`/`avr_we`/`avr_data` and returns read data or write completion on a response strobe.
- Sits on the AVR side. It is also used as the bus driver in system-level benches.

---
 rtl/avr_bus_master.sv | 143 ++++++++++++++
 tb/tb_avr_bus_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_bus_master.sv
// AVR-side bus master: serialises the SRAM address into the CPLD shift
// register, then runs the SRAM read/write strobe handshake and reports
// completion on a one-cycle response pulse.
module avr_bus_master #(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACCESS_CYC = 4
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              avr_si,
    output logic              avr_sreg_en,
    output logic              avr_oe,
    output logic              avr_we,
    inout  wire  [DATA_W-1:0] avr_data
);

    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned ACC_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        ACCESS,
        RECOVER
    } state_t;

    state_t               state;
    logic                 write_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [ADDR_W-1:0]    shift_q;
    logic                 addr_loaded;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [ACC_CNT_W-1:0] acc_cnt;
    logic                 drive_q;

    // Write data is driven from a register; released one cycle after the strobe
    assign avr_data = drive_q ? wdata_q : {DATA_W{1'bz}};

    // Command sequencer: address shift, latch, strobe access, recovery
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            avr_si      <= 1'b0;
            avr_sreg_en <= 1'b1;
            avr_oe      <= 1'b1;
            avr_we      <= 1'b1;
            drive_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            addr_loaded <= 1'b0;
            bit_cnt     <= '0;
            acc_cnt     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        write_q   <= cmd_write;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        if (addr_loaded && (addr_q == cmd_addr)) begin
                            // sreg already holds this address: go straight to the strobe
                            state   <= ACCESS;
                            avr_oe  <= cmd_write;
                            avr_we  <= ~cmd_write;
                            drive_q <= cmd_write;
                            acc_cnt <= '0;
                        end else begin
                            state       <= SHIFT;
                            addr_loaded <= 1'b0;
                            avr_sreg_en <= 1'b0;
                            avr_si      <= cmd_addr[ADDR_W-1];
                            shift_q     <= {cmd_addr[ADDR_W-2:0], 1'b0};
                            bit_cnt     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt == BIT_CNT_W'(ADDR_W - 1)) begin
                        state       <= LATCH;
                        avr_sreg_en <= 1'b1;
                        avr_si      <= 1'b0;
                        bit_cnt     <= '0;
                    end else begin
                        avr_si  <= shift_q[ADDR_W-1];
                        shift_q <= shift_q << 1;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    end
                end
                LATCH: begin
                    state       <= ACCESS;
                    addr_loaded <= 1'b1;
                    avr_oe      <= write_q;
                    avr_we      <= ~write_q;
                    drive_q     <= write_q;
                    acc_cnt     <= '0;
                end
                ACCESS: begin
                    if (acc_cnt == ACC_CNT_W'(ACCESS_CYC - 1)) begin
                        state     <= RECOVER;
                        avr_oe    <= 1'b1;
                        avr_we    <= 1'b1;
                        rsp_valid <= 1'b1;
                        acc_cnt   <= '0;
                        if (!write_q) begin
                            rsp_rdata <= avr_data;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + ACC_CNT_W'(1);
                    end
                end
                RECOVER: begin
                    // Write data held through this cycle for SRAM hold time
                    state     <= IDLE;
                    drive_q   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    drive_q   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_bus_master.sv
// Directed bench for avr_bus_master: shift path, address reuse, write,
// held cmd_valid and asynchronous reset aborts.
module tb_avr_bus_master;

    logic        avr_clk;
    logic        avr_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [20:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        avr_si;
    logic        avr_sreg_en;
    logic        avr_oe;
    logic        avr_we;
    wire  [7:0]  avr_data;

    // SRAM model drives while avr_oe is low; probe drives to expose an idle bus
    logic        probe;
    logic [7:0]  sram_val;
    assign avr_data = (!avr_oe || probe) ? sram_val : 8'hzz;

    int checks;
    int errors;

    avr_bus_master #(
        .ADDR_W    (21),
        .DATA_W    (8),
        .ACCESS_CYC(4)
    ) dut (
        .avr_clk    (avr_clk),
        .avr_reset  (avr_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .avr_si     (avr_si),
        .avr_sreg_en(avr_sreg_en),
        .avr_oe     (avr_oe),
        .avr_we     (avr_we),
        .avr_data   (avr_data)
    );

    initial avr_clk = 1'b0;
    always #5 avr_clk = ~avr_clk;

    // Present a command from a negedge; returns at the negedge of cycle k+1
    task automatic issue(input logic w, input logic [20:0] a, input logic [7:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(posedge avr_clk);
        @(negedge avr_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge avr_clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, avr_si, avr_sreg_en, avr_oe, avr_we} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b rv=%b rd=%h si=%b en=%b oe=%b we=%b", cmd_ready, rsp_valid, rsp_rdata, avr_si, avr_sreg_en, avr_oe, avr_we);
        end
        avr_reset = 1'b0;
        @(negedge avr_clk);
        probe = 1'b1; sram_val = 8'h5A; #1;
        checks++;
        if (avr_data !== 8'h5A) begin errors++; $display("FAIL reset_bus_idle got %h want 5a", avr_data); end
        probe = 1'b0;
        @(negedge avr_clk);
        // Asynchronous reset in the middle of a shift
        issue(1'b0, 21'h1FFFFF, 8'h00);
        checks++;
        if ({avr_sreg_en, avr_si} !== 2'b01) begin errors++; $display("FAIL pre_reset_shift got en=%b si=%b want 0 1", avr_sreg_en, avr_si); end
        @(negedge avr_clk);
        #2 avr_reset = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, avr_si, avr_sreg_en, avr_oe, avr_we} !== 6'b100111) begin
            errors++;
            $display("FAIL async_reset got rdy=%b rv=%b si=%b en=%b oe=%b we=%b", cmd_ready, rsp_valid, avr_si, avr_sreg_en, avr_oe, avr_we);
        end
        @(negedge avr_clk);
        avr_reset = 1'b0;
        @(negedge avr_clk);
    endtask

    task automatic test_read_shift();
        logic [20:0] a;
        a = 21'h1CCCF;
        sram_val = 8'hAA;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got %b want 1", cmd_ready); end
        issue(1'b0, a, 8'h00);
        for (int n = 0; n < 21; n++) begin
            if (n != 0) @(negedge avr_clk);
            checks++;
            if ({avr_sreg_en, avr_si} !== {1'b0, a[20-n]}) begin
                errors++;
                $display("FAIL rs_shift_bit%0d got en=%b si=%b want en=0 si=%b", n, avr_sreg_en, avr_si, a[20-n]);
            end
        end
        @(negedge avr_clk);
        checks++;
        if ({avr_sreg_en, avr_si, avr_oe} !== 3'b101) begin errors++; $display("FAIL rs_latch got en=%b si=%b oe=%b want 1 0 1", avr_sreg_en, avr_si, avr_oe); end
        for (int i = 0; i < 4; i++) begin
            @(negedge avr_clk);
            checks++;
            if ({avr_oe, avr_we, rsp_valid, avr_data} !== {1'b0, 1'b1, 1'b0, 8'hAA}) begin
                errors++;
                $display("FAIL rs_access%0d got oe=%b we=%b rv=%b data=%h want 0 1 0 aa", i, avr_oe, avr_we, rsp_valid, avr_data);
            end
        end
        @(negedge avr_clk);
        checks++;
        if ({rsp_valid, avr_oe, rsp_rdata} !== {1'b1, 1'b1, 8'hAA}) begin
            errors++;
            $display("FAIL rs_response got rv=%b oe=%b rd=%h want 1 1 aa", rsp_valid, avr_oe, rsp_rdata);
        end
        @(negedge avr_clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rs_idle got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_reuse();
        sram_val = 8'hBB;
        issue(1'b0, 21'h1CCCF, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge avr_clk);
            checks++;
            if ({avr_oe, avr_sreg_en, rsp_valid} !== 3'b010) begin
                errors++;
                $display("FAIL ru_access%0d got oe=%b en=%b rv=%b want 0 1 0", i, avr_oe, avr_sreg_en, rsp_valid);
            end
        end
        @(negedge avr_clk);
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL ru_response got rv=%b rd=%h want 1 bb", rsp_valid, rsp_rdata); end
        @(negedge avr_clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL ru_idle got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_write();
        issue(1'b1, 21'h1CCCF, 8'hEE);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge avr_clk);
            checks++;
            if ({avr_we, avr_oe, avr_sreg_en, avr_data} !== {1'b0, 1'b1, 1'b1, 8'hEE}) begin
                errors++;
                $display("FAIL wr_access%0d got we=%b oe=%b en=%b data=%h want 0 1 1 ee", i, avr_we, avr_oe, avr_sreg_en, avr_data);
            end
        end
        @(negedge avr_clk);
        checks++;
        if ({rsp_valid, avr_we, avr_data, rsp_rdata} !== {1'b1, 1'b1, 8'hEE, 8'hBB}) begin
            errors++;
            $display("FAIL wr_recover got rv=%b we=%b data=%h rd=%h want 1 1 ee bb", rsp_valid, avr_we, avr_data, rsp_rdata);
        end
        @(negedge avr_clk);
        probe = 1'b1; sram_val = 8'h5A; #1;
        checks++;
        if ({cmd_ready, avr_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL wr_release got rdy=%b data=%h want 1 5a", cmd_ready, avr_data); end
        probe = 1'b0;
    endtask

    task automatic test_new_addr_held_valid();
        logic [20:0] b;
        b = 21'h000001;
        sram_val  = 8'h3C;
        cmd_write = 1'b0;
        cmd_addr  = b;
        cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        @(posedge avr_clk);
        @(negedge avr_clk);
        for (int n = 0; n < 21; n++) begin
            if (n != 0) @(negedge avr_clk);
            checks++;
            if ({avr_sreg_en, avr_si, cmd_ready} !== {1'b0, b[20-n], 1'b0}) begin
                errors++;
                $display("FAIL na_shift_bit%0d got en=%b si=%b rdy=%b want 0 %b 0", n, avr_sreg_en, avr_si, cmd_ready, b[20-n]);
            end
        end
        @(negedge avr_clk);
        checks++;
        if ({avr_sreg_en, cmd_ready} !== 2'b10) begin errors++; $display("FAIL na_latch got en=%b rdy=%b want 1 0", avr_sreg_en, cmd_ready); end
        repeat (5) @(negedge avr_clk);
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL na_response got rv=%b rd=%h want 1 3c", rsp_valid, rsp_rdata); end
        @(negedge avr_clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL na_idle got rdy=%b want 1", cmd_ready); end
        @(negedge avr_clk);
        // Held request accepted in IDLE, same address -> reuse path
        checks++;
        if ({avr_oe, avr_sreg_en, cmd_ready} !== 3'b010) begin
            errors++;
            $display("FAIL na_reaccept got oe=%b en=%b rdy=%b want 0 1 0", avr_oe, avr_sreg_en, cmd_ready);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge avr_clk);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL na_reaccept_rsp got rv=%b want 1", rsp_valid); end
        @(negedge avr_clk);
    endtask

    task automatic test_reset_during_write();
        int pulses;
        issue(1'b1, 21'h000001, 8'h77);
        checks++;
        if ({avr_we, avr_data} !== {1'b0, 8'h77}) begin errors++; $display("FAIL rw_access got we=%b data=%h want 0 77", avr_we, avr_data); end
        @(negedge avr_clk);
        #2 avr_reset = 1'b1;
        #1;
        checks++;
        if ({avr_we, avr_oe, rsp_valid, cmd_ready, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL rw_reset got we=%b oe=%b rv=%b rdy=%b rd=%h want 1 1 0 1 00", avr_we, avr_oe, rsp_valid, cmd_ready, rsp_rdata);
        end
        probe = 1'b1; sram_val = 8'h5A; #1;
        checks++;
        if (avr_data !== 8'h5A) begin errors++; $display("FAIL rw_bus_released got %h want 5a", avr_data); end
        probe = 1'b0;
        @(negedge avr_clk);
        avr_reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge avr_clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rw_no_response got %0d pulses want 0", pulses); end
        sram_val = 8'hC3;
        issue(1'b0, 21'h000001, 8'h00);
        checks++;
        if (avr_sreg_en !== 1'b0) begin errors++; $display("FAIL rw_reshift got en=%b want 0", avr_sreg_en); end
        repeat (26) @(negedge avr_clk);
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL rw_after_reset_rsp got rv=%b rd=%h want 1 c3", rsp_valid, rsp_rdata); end
        @(negedge avr_clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        avr_reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        probe     = 1'b0;
        sram_val  = 8'h00;
        test_reset();
        test_read_shift();
        test_reuse();
        test_write();
        test_new_addr_held_valid();
        test_reset_during_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
